// File: rtl/radix4_input_gather.sv
// Radix-4 input gather: packs four streamed coefficients into one butterfly group with twiddle address.
// Build macro GATHER_REDUCE_EN enables a conditional subtract of Q on every accepted coefficient.
module radix4_input_gather #(
  parameter int width    = 16,
  parameter int N_GROUPS = 64,
  parameter int GRP_W    = 6,
  parameter int Q        = 3329
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_select,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_1,
  output logic [width-1:0] out_2,
  output logic [width-1:0] out_3,
  output logic [width-1:0] out_4,
  output logic [GRP_W-1:0] tw_addr,
  output logic             out_select,
  output logic             out_last
);

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GROUPS - 1);

  logic [1:0]       cnt_r;
  logic [GRP_W-1:0] grp_r;
  logic [width-1:0] slot0_r;
  logic [width-1:0] slot1_r;
  logic [width-1:0] slot2_r;
  logic             mode_r;

  logic [width-1:0] data_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             load_s;
  logic             grp_last_s;

`ifdef GATHER_REDUCE_EN
  function automatic logic [width-1:0] cond_sub_q(input logic [width-1:0] d);
    logic [width:0] q_ext;
    q_ext = (width + 1)'(Q);
    if ({1'b0, d} >= q_ext) begin
      cond_sub_q = d - q_ext[width-1:0];
    end else begin
      cond_sub_q = d;
    end
  endfunction

  assign data_s = cond_sub_q(in_data);
`else
  logic unused_q_s;
  assign unused_q_s = (Q > 0);
  assign data_s     = in_data;
`endif

  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;
  assign load_s     = in_fire_s && (cnt_r == 2'd3);
  assign grp_last_s = (grp_r == LAST_GRP);

  // Input acceptance: the 4th coefficient may only enter when the output register is free or draining.
  always_comb begin
    in_ready = 1'b0;
    if (clear) begin
      in_ready = 1'b0;
    end else if (cnt_r != 2'd3) begin
      in_ready = 1'b1;
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  // Slot/group counters and output valid; clear flushes the frame and drops any pending group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 2'd0;
      grp_r     <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      cnt_r     <= 2'd0;
      grp_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_s) begin
        cnt_r     <= 2'd0;
        grp_r     <= grp_last_s ? '0 : grp_r + GRP_W'(1);
        out_valid <= 1'b1;
      end else begin
        cnt_r     <= in_fire_s ? cnt_r + 2'd1 : cnt_r;
        grp_r     <= grp_r;
        out_valid <= out_fire_s ? 1'b0 : out_valid;
      end
    end
  end

  // Slot and output data path; these registers are deliberately left untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_r    <= '0;
      slot1_r    <= '0;
      slot2_r    <= '0;
      mode_r     <= 1'b0;
      out_1      <= '0;
      out_2      <= '0;
      out_3      <= '0;
      out_4      <= '0;
      tw_addr    <= '0;
      out_select <= 1'b0;
      out_last   <= 1'b0;
    end else if (in_fire_s) begin
      case (cnt_r)
        2'd0: begin
          slot0_r <= data_s;
          // Mode is captured only on the first coefficient of a frame.
          mode_r  <= (grp_r == '0) ? in_select : mode_r;
        end
        2'd1: slot1_r <= data_s;
        2'd2: slot2_r <= data_s;
        2'd3: begin
          out_1      <= slot0_r;
          out_2      <= slot1_r;
          out_3      <= slot2_r;
          out_4      <= data_s;
          tw_addr    <= grp_r;
          out_last   <= grp_last_s;
          out_select <= mode_r;
        end
        default: slot0_r <= slot0_r;
      endcase
    end else begin
      mode_r <= mode_r;
    end
  end

endmodule

// File: tb/tb_radix4_input_gather.sv
// Scoreboard bench for radix4_input_gather: frame-level reference model feeds an expected-group queue.
module tb_radix4_input_gather;

  localparam int W  = 16;
  localparam int NG = 64;
  localparam int GW = 6;
  localparam int Q  = 3329;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_select;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_1, out_2, out_3, out_4;
  logic [GW-1:0] tw_addr;
  logic          out_select;
  logic          out_last;

  always #5 clk = ~clk;

  radix4_input_gather #(.width(W), .N_GROUPS(NG), .GRP_W(GW), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_select(in_select), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4), .tw_addr(tw_addr),
    .out_select(out_select), .out_last(out_last)
  );

  typedef struct packed {
    logic [W-1:0]  d1, d2, d3, d4;
    logic [GW-1:0] tw;
    logic          last;
    logic          sel;
  } grp_t;

  grp_t         exp_q[$];
  logic [W-1:0] pend[$];
  int           frame_pos = 0;
  logic         frame_mode = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           groups_seen = 0;

  function automatic logic [W-1:0] ref_value(input logic [W-1:0] d);
`ifdef GATHER_REDUCE_EN
    return (int'(d) >= Q) ? W'(int'(d) - Q) : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [W-1:0] next_coef(input int kind, input int base, input int idx);
    logic [W-1:0] special [4];
    special = '{16'd3329, 16'd3330, 16'd6657, 16'd5};
    case (kind)
      0: return W'(base + idx);
`ifdef GATHER_REDUCE_EN
      1: return W'($urandom_range(2 * Q - 1));
`else
      1: return W'($urandom);
`endif
      default: return special[idx % 4];
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    frame_pos = 0;
  endtask

  // Reference: every 4th accepted coefficient of a frame closes a group; frame = 4*NG coefficients.
  task automatic model_accept(input logic [W-1:0] d, input logic sel);
    grp_t g;
    if (frame_pos == 0) frame_mode = sel;
    pend.push_back(ref_value(d));
    frame_pos++;
    if (pend.size() == 4) begin
      g.d1   = pend[0];
      g.d2   = pend[1];
      g.d3   = pend[2];
      g.d4   = pend[3];
      g.tw   = GW'(frame_pos / 4 - 1);
      g.last = (frame_pos == 4 * NG);
      g.sel  = frame_mode;
      exp_q.push_back(g);
      pend.delete();
      if (frame_pos == 4 * NG) frame_pos = 0;
    end
  endtask

  // Monitor: compare presented group every cycle (also proves hold under stall), pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear) begin
        if (out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        model_reset();
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_group tw=%0d out_1=%0h with empty queue at %0t", tw_addr, out_1, $time);
          end else begin
            check("group", grp_t'({out_1, out_2, out_3, out_4, tw_addr, out_last, out_select}), exp_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              groups_seen++;
            end
          end
        end
        if (in_valid && in_ready) model_accept(in_data, in_select);
      end
    end
  end

  task automatic run_stream(input int n, input int kind, input int base, input int rdy_pct,
                            input int vld_pct, input int clr_pm, input logic sel_a,
                            input logic sel_b, input int sel_sw);
    int idx = 0;
    int guard = 0;
    logic [W-1:0] d;
    d = next_coef(kind, base, 0);
    while (idx < n && guard < 5000) begin
      in_valid  = ($urandom_range(99) < vld_pct);
      in_data   = d;
      in_select = (idx < sel_sw) ? sel_a : sel_b;
      out_ready = ($urandom_range(99) < rdy_pct);
      clear     = ($urandom_range(999) < clr_pm);
      @(negedge clk);
      if (in_valid && in_ready) begin
        idx++;
        d = next_coef(kind, base, idx);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout accepted=%0d required=%0d", idx, n);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    time t0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_select = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_tw_addr", tw_addr, 0);
    check("reset_last_sel", {out_last, out_select}, 0);
    check("reset_data", {out_1, out_2, out_3, out_4}, 0);
    check("reset_in_ready", in_ready, 1);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame 0..255, full throughput
    g0 = groups_seen;
    t0 = $time;
    run_stream(256, 0, 0, 100, 100, 0, 1'b0, 1'b0, 0);
    check("throughput_cycles", ($time - t0) / 10, 256);
    drain();
    check("frame_group_count", groups_seen - g0, 64);

    // Backpressure: group 0 held while slots fill 4,5,6
    run_stream(7, 0, 0, 0, 100, 0, 1'b0, 1'b0, 0);
    in_valid = 1'b1; in_data = 16'd7; out_ready = 1'b0;
    #2;
    check("bp_in_ready_stall", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", {out_1, out_4, tw_addr}, {16'd0, 16'd3, 6'd0});
    @(posedge clk);
    #1;
    check("bp_hold_data_2", {out_1, out_4, tw_addr}, {16'd0, 16'd3, 6'd0});
    out_ready = 1'b1;
    #2;
    check("bp_in_ready_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_group", {out_valid, out_1, out_4, tw_addr}, {1'b1, 16'd4, 16'd7, 6'd1});
    drain();
    pulse_clear();

    // Clear at slot 2 of group 5: coincident sample dropped, new group restarts at tw 0
    run_stream(22, 0, 100, 100, 100, 0, 1'b0, 1'b0, 0);
    in_valid = 1'b1; in_data = 16'hBEEF; clear = 1'b1; out_ready = 1'b1;
    #2;
    check("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clear_out_valid", out_valid, 0);
    run_stream(4, 0, 500, 100, 100, 0, 1'b0, 1'b0, 0);
    check("clear_regroup", {out_valid, out_1, out_4, tw_addr}, {1'b1, 16'd500, 16'd503, 6'd0});
    drain();
    pulse_clear();

    // Mode latching: INTT frame with a mid-frame toggle, then NTT frame with a toggle
    run_stream(256, 0, 0, 100, 100, 0, 1'b1, 1'b0, 100);
    drain();
    run_stream(256, 0, 0, 100, 100, 0, 1'b0, 1'b1, 50);
    drain();

    // Optional reduction corner values
    run_stream(4, 2, 0, 100, 100, 0, 1'b0, 1'b0, 0);
`ifdef GATHER_REDUCE_EN
    check("reduce_values", {out_1, out_2, out_3, out_4}, {16'd0, 16'd1, 16'd3328, 16'd5});
`else
    check("reduce_values", {out_1, out_2, out_3, out_4}, {16'd3329, 16'd3330, 16'd6657, 16'd5});
`endif
    drain();

    // Random traffic with random backpressure, mode and occasional clears
    run_stream(600, 1, 0, 60, 70, 20, 1'b0, 1'($urandom), 0);
    drain();
    run_stream(300, 1, 0, 85, 90, 5, 1'b1, 1'b0, 3);
    drain();
    pulse_clear();

    // Async reset while a group is stalled
    run_stream(8, 0, 40, 100, 100, 0, 1'b0, 1'b0, 0);
    out_ready = 1'b0;
    #1;
    check("prereset_valid_tw", {out_valid, tw_addr}, {1'b1, 6'd1});
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("async_reset_valid_tw", {out_valid, tw_addr}, {1'b0, 6'd0});
    check("async_reset_data", out_1, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_stream(8, 0, 900, 100, 100, 0, 1'b1, 1'b1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
